// File: rtl/shared_counter_arbiter.sv
// Round-robin arbiter that lends one shared down-counter to a single requester at a time.
// Each grant runs a timed interval of req_len+1 cycles, then ends with a done pulse or an abort.
module shared_counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_len,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     aborted,
    output logic                     busy,
    output logic [WIDTH-1:0]         count,
    output logic [OW-1:0]            owner
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [OW-1:0]      owner_q, owner_d;

    logic [WIDTH-1:0]   len_arr  [NUM_REQ];
    logic [OW-1:0]      cand_idx [NUM_REQ];
    logic [OW-1:0]      win_idx;
    logic               win_valid;

    // owner_q doubles as last_owner: candidate k is the k-th index after it, with wrap.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign len_arr[gi]  = req_len[gi*WIDTH +: WIDTH];
            assign cand_idx[gi] = OW'((int'(owner_q) + gi + 1) % NUM_REQ);
        end
    endgenerate

    assign win_valid = |req;

    always_comb begin
        win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        aborted_d = 1'b0;
        busy_d    = busy_q;
        count_d   = count_q;
        owner_d   = owner_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (win_valid) begin
                    state_d          = ST_RUN;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    count_d          = len_arr[win_idx];
                    busy_d           = 1'b1;
                end
            end
            ST_RUN: begin
                // Abort wins over completion, even on the count==0 cycle.
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                end else if (count_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            owner_q   <= OW'(NUM_REQ - 1);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            owner_q   <= owner_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign busy    = busy_q;
    assign count   = count_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Bench for shared_counter_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked cycle-by-cycle against an interval-level reference model.
module tb_shared_counter_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_len;
    logic           abort;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           aborted;
    logic           busy;
    logic [W-1:0]   count;
    logic [1:0]     owner;

    shared_counter_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .abort(abort),
        .grant(grant), .done(done), .aborted(aborted), .busy(busy),
        .count(count), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [N-1:0] done;
        logic         aborted;
        logic         busy;
        logic [W-1:0] count;
        logic [1:0]   owner;
    } out_t;

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N*W-1:0] lens;
        logic           abort;
        out_t           exp;
    } vec_t;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: phase 0=idle 1=interval running 2=completion cycle.
    int m_phase;
    int m_owner;
    int m_left;
    bit m_done;
    bit m_ab;

    function automatic out_t ex(input logic [N-1:0] g, input logic [N-1:0] d, input logic a,
                                input logic b, input int c, input int o);
        out_t r;
        r.grant = g; r.done = d; r.aborted = a; r.busy = b;
        r.count = W'(c); r.owner = 2'(o);
        return r;
    endfunction

    function automatic logic [N*W-1:0] lens4(input int l3, input int l2, input int l1, input int l0);
        return {W'(l3), W'(l2), W'(l1), W'(l0)};
    endfunction

    function automatic vec_t mk(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] l,
                                input logic a, input out_t e);
        vec_t v;
        v.rst = r; v.req = q; v.lens = l; v.abort = a; v.exp = e;
        return v;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] l,
                              input logic a);
        if (r) begin
            m_phase = 0; m_owner = N - 1; m_left = 0; m_done = 0; m_ab = 0;
        end else begin
            m_done = 0; m_ab = 0;
            if (m_phase == 0) begin
                if (q != '0) begin
                    int w;
                    w = -1;
                    for (int k = 1; k <= N; k++) begin
                        int idx;
                        idx = (m_owner + k) % N;
                        if (w < 0 && q[idx]) w = idx;
                    end
                    m_phase = 1; m_owner = w; m_left = int'(l[w*W +: W]);
                end
            end else if (m_phase == 1) begin
                if (a) begin
                    m_phase = 0; m_ab = 1;
                end else if (m_left == 0) begin
                    m_phase = 2; m_done = 1;
                end else begin
                    m_left = m_left - 1;
                end
            end else begin
                m_phase = 0;
            end
        end
    endtask

    function automatic out_t model_out();
        out_t r;
        r = '0;
        if (m_phase == 1) r.grant[m_owner] = 1'b1;
        if (m_done) r.done[m_owner] = 1'b1;
        r.aborted = m_ab;
        r.busy    = (m_phase == 1);
        r.count   = W'(m_left);
        r.owner   = 2'(m_owner);
        return r;
    endfunction

    task automatic apply(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] l, input logic a);
        rst = r; req = q; req_len = l; abort = a;
        model_step(r, q, l, a);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input out_t e);
        out_t act;
        act = {grant, done, aborted, busy, count, owner};
        tests_run++;
        if (act !== e) begin
            tests_failed++;
            $display("FAIL %s: got grant=%b done=%b aborted=%b busy=%b count=%0d owner=%0d; expected grant=%b done=%b aborted=%b busy=%b count=%0d owner=%0d",
                     name, act.grant, act.done, act.aborted, act.busy, act.count, act.owner,
                     e.grant, e.done, e.aborted, e.busy, e.count, e.owner);
        end
    endtask

    vec_t tbl[19];

    initial begin
        logic [N-1:0]   rq;
        logic [N*W-1:0] ln;
        bit             found;

        rst = 1'b1; req = '0; req_len = '0; abort = 1'b0;

        // Single request, ignored req_len change and req drop, zero length, aborts.
        tbl[0]  = mk(1, 4'b0000, lens4(0,0,0,0), 0, ex(4'b0000, 4'b0000, 0, 0, 0, 3));
        tbl[1]  = mk(0, 4'b0001, lens4(0,0,0,3), 0, ex(4'b0001, 4'b0000, 0, 1, 3, 0));
        tbl[2]  = mk(0, 4'b0000, lens4(0,0,0,9), 0, ex(4'b0001, 4'b0000, 0, 1, 2, 0));
        tbl[3]  = mk(0, 4'b0000, lens4(0,0,0,9), 0, ex(4'b0001, 4'b0000, 0, 1, 1, 0));
        tbl[4]  = mk(0, 4'b0000, lens4(0,0,0,9), 0, ex(4'b0001, 4'b0000, 0, 1, 0, 0));
        tbl[5]  = mk(0, 4'b0000, lens4(0,0,0,9), 0, ex(4'b0000, 4'b0001, 0, 0, 0, 0));
        tbl[6]  = mk(0, 4'b0000, lens4(0,0,0,0), 1, ex(4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl[7]  = mk(0, 4'b0000, lens4(0,0,0,0), 1, ex(4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl[8]  = mk(0, 4'b0100, lens4(0,0,0,0), 0, ex(4'b0100, 4'b0000, 0, 1, 0, 2));
        tbl[9]  = mk(0, 4'b0000, lens4(0,0,0,0), 0, ex(4'b0000, 4'b0100, 0, 0, 0, 2));
        tbl[10] = mk(0, 4'b0000, lens4(0,0,0,0), 0, ex(4'b0000, 4'b0000, 0, 0, 0, 2));
        tbl[11] = mk(0, 4'b0010, lens4(0,0,10,0), 0, ex(4'b0010, 4'b0000, 0, 1, 10, 1));
        tbl[12] = mk(0, 4'b0000, lens4(0,0,10,0), 0, ex(4'b0010, 4'b0000, 0, 1, 9, 1));
        tbl[13] = mk(0, 4'b0000, lens4(0,0,10,0), 0, ex(4'b0010, 4'b0000, 0, 1, 8, 1));
        tbl[14] = mk(0, 4'b0000, lens4(0,0,10,0), 1, ex(4'b0000, 4'b0000, 1, 0, 8, 1));
        tbl[15] = mk(0, 4'b0000, lens4(0,0,0,0), 0, ex(4'b0000, 4'b0000, 0, 0, 8, 1));
        tbl[16] = mk(0, 4'b0001, lens4(0,0,0,0), 0, ex(4'b0001, 4'b0000, 0, 1, 0, 0));
        tbl[17] = mk(0, 4'b0000, lens4(0,0,0,0), 1, ex(4'b0000, 4'b0000, 1, 0, 0, 0));
        tbl[18] = mk(0, 4'b0000, lens4(0,0,0,0), 0, ex(4'b0000, 4'b0000, 0, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].rst, tbl[i].req, tbl[i].lens, tbl[i].abort);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Round-robin with all requesters held and zero-length intervals.
        apply(1, 4'b0000, '0, 0);
        for (int i = 0; i < 5; i++) begin
            logic [N-1:0] oh;
            oh = '0;
            oh[i % N] = 1'b1;
            found = 0;
            for (int c = 0; c < 6 && !found; c++) begin
                apply(0, 4'b1111, '0, 0);
                if (grant != '0) found = 1;
            end
            if (!found) begin
                tests_run++; tests_failed++;
                $display("FAIL rr_wait[%0d]: no grant within 6 cycles, required %b", i, oh);
            end else begin
                check($sformatf("rr_grant[%0d]", i), ex(oh, 4'b0000, 0, 1, 0, i % N));
                apply(0, 4'b1111, '0, 0);
                check($sformatf("rr_done[%0d]", i), ex(4'b0000, oh, 0, 0, 0, i % N));
            end
        end

        // Reset in the middle of an interval, then first search starts at index 0.
        apply(1, 4'b0000, '0, 0);
        apply(0, 4'b0001, lens4(4,4,4,7), 0);
        found = (count == 8'd5);
        for (int c = 0; c < 10 && !found; c++) begin
            apply(0, 4'b0000, lens4(4,4,4,7), 0);
            if (count == 8'd5) found = 1;
        end
        if (!found) begin
            tests_run++; tests_failed++;
            $display("FAIL rst_mid_wait: count=%0d never reached required 5", count);
        end
        apply(1, 4'b1111, lens4(4,4,4,7), 1);
        check("rst_mid_run", ex(4'b0000, 4'b0000, 0, 0, 0, 3));
        apply(0, 4'b1010, lens4(4,4,4,7), 0);
        check("after_rst_grant", ex(4'b0010, 4'b0000, 0, 1, 4, 1));

        // Randomized traffic against the reference model.
        apply(1, 4'b0000, '0, 0);
        rq = '0;
        ln = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r;
            logic a;
            if ($urandom_range(0, 1) == 0) rq = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 31) == 0) ln[i*W +: W] = W'($urandom_range(0, 255));
                else ln[i*W +: W] = W'($urandom_range(0, 5));
            end
            a = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 199) == 0);
            apply(r, rq, ln, a);
            check($sformatf("random[%0d]", cyc), model_out());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
